// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
// The optional wait timeout is enabled by defining ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Wait-cycle counter and sticky error flag for the arbiter.
// The arbiter instantiates this only when ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic wait_i,
    output logic expire_o,
    output logic err_o
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    // Expire on the wait cycle that would bring the count up to TIMEOUT_CYC.
    assign expire_o = wait_i && (cnt_q == LAST_WAIT);
    assign err_o    = err_q;

    always_comb begin
        // NOTE: assign a default first so no path leaves cnt_d unassigned and infers a latch.
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (expire_o) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store, data first.
// Define ARB_TIMEOUT_EN to add the mem_ready timeout and sticky mem_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pipe_stall,
    output logic              mem_err
);

    arb_state_e        state_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q, dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    logic dm_go, if_go, timeout, done;

    // A request whose ack is high this cycle is being released; do not re-issue it.
    assign dm_go = dm_req & ~dm_ack_q;
    assign if_go = if_req & ~if_ack_q;

`ifdef ARB_TIMEOUT_EN
    logic start;
    assign start = (state_q == IDLE) && (dm_go || if_go);

    arb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .wait_i  (mem_req_q & ~mem_ready),
        .expire_o(timeout),
        .err_o   (mem_err)
    );
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    assign done = mem_ready | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dm_go) begin
                        state_q     <= DATA;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (if_go) begin
                        state_q    <= FETCH;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                    end
                end
                DATA: begin
                    if (done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        dm_ack_q  <= 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_q <= timeout ? '0 : mem_rdata;
                        end
                    end
                end
                FETCH: begin
                    if (done) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= timeout ? '0 : mem_rdata;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign if_ack     = if_ack_q;
    assign dm_ack     = dm_ack_q;
    assign if_rdata   = if_rdata_q;
    assign dm_rdata   = dm_rdata_q;
    assign pipe_stall = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);

endmodule
